// File: rtl/calc_pkg.sv
// calc_pkg: opcode encoding and FSM state type shared by the calc_unit slice.
// The MUL state only exists when CALC_MUL_EN is defined.
package calc_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_OR   = 3'b010;
  localparam logic [2:0] OP_NEG  = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_XOR  = 3'b101;
  localparam logic [2:0] OP_MUL  = 3'b110;
  localparam logic [2:0] OP_RSVD = 3'b111;

`ifdef CALC_MUL_EN
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DONE = 2'd2
  } state_t;
`endif

endpackage

// File: rtl/calc_mul_seq.sv
// calc_mul_seq: iterative shift-add multiplier, one partial product per cycle.
// start latches the operands; WIDTH steps later done pulses for one cycle
// with the full product available on product. Only instantiated when
// CALC_MUL_EN is defined.
module calc_mul_seq #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0]   a_reg;
  logic [WIDTH-1:0]   b_reg;
  logic [2*WIDTH-1:0] acc_reg;
  logic [CW-1:0]      cnt_reg;
  logic               busy_reg;
  logic               done_reg;

  // Partial product for each multiplier bit: a shifted into place, or zero.
  logic [2*WIDTH-1:0] pp [WIDTH];

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_pp
      assign pp[gi] = b_reg[gi] ? ({{WIDTH{1'b0}}, a_reg} << gi) : '0;
    end
  endgenerate

  // Operand capture on start, then accumulate one partial product per cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg    <= '0;
      b_reg    <= '0;
      acc_reg  <= '0;
      cnt_reg  <= '0;
      busy_reg <= 1'b0;
      done_reg <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (start) begin
        a_reg    <= a;
        b_reg    <= b;
        acc_reg  <= '0;
        cnt_reg  <= '0;
        busy_reg <= 1'b1;
      end else if (busy_reg) begin
        acc_reg <= acc_reg + pp[cnt_reg];
        if (cnt_reg == CW'(WIDTH - 1)) begin
          cnt_reg  <= '0;
          busy_reg <= 1'b0;
          done_reg <= 1'b1;
        end else begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end
    end
  end

  assign done    = done_reg;
  assign product = acc_reg;

endmodule

// File: rtl/calc_unit.sv
// calc_unit: handshaked ALU with one registered result plus flags.
// Single-cycle ops are computed combinationally and registered on accept;
// multiply goes through calc_mul_seq when CALC_MUL_EN is defined, otherwise
// op 110 reports err like the reserved opcode.
module calc_unit
  import calc_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] z,
  output logic             carry,
  output logic             zero,
  output logic             err
);

  state_t state_reg, state_next;

  logic accept;
  logic is_mul;

  logic [WIDTH:0]   sum_w;
  logic [WIDTH-1:0] alu_z;
  logic             alu_carry;
  logic             alu_err;
  logic             alu_zero;

  logic [WIDTH-1:0] z_reg;
  logic             carry_reg;
  logic             zero_reg;
  logic             err_reg;

`ifdef CALC_MUL_EN
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_product;

  assign is_mul = (op == OP_MUL);

  calc_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (accept && is_mul),
    .a       (a),
    .b       (b),
    .done    (mul_done),
    .product (mul_product)
  );
`else
  assign is_mul = 1'b0;
`endif

  assign accept = in_valid && in_ready;

  // Single-cycle ALU; anything it cannot compute is flagged as err.
  always_comb begin
    sum_w     = {1'b0, a} + {1'b0, b};
    alu_z     = '0;
    alu_carry = 1'b0;
    alu_err   = 1'b0;
    case (op)
      OP_ADD: begin
        alu_z     = sum_w[WIDTH-1:0];
        alu_carry = sum_w[WIDTH];
      end
      OP_SUB: begin
        alu_z     = a - b;
        alu_carry = (a < b);
      end
      OP_OR:  alu_z = a | b;
      OP_NEG: alu_z = ~a + WIDTH'(1);
      OP_AND: alu_z = a & b;
      OP_XOR: alu_z = a ^ b;
`ifdef CALC_MUL_EN
      OP_MUL: alu_z = '0;
`endif
      default: alu_err = 1'b1;
    endcase
    alu_zero = !alu_err && (alu_z == '0);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic; a result handshake always returns to IDLE first.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (accept) state_next = is_mul ? state_t'(2'd1) : ST_DONE;
      end
`ifdef CALC_MUL_EN
      ST_MUL: begin
        if (mul_done) state_next = ST_DONE;
      end
`endif
      ST_DONE: begin
        if (out_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Handshake outputs decoded from state; reset forces in_ready low.
  always_comb begin
    in_ready  = (state_reg == ST_IDLE) && !rst;
    out_valid = (state_reg == ST_DONE);
  end

  // Result registers load on a single-cycle accept or multiply completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      z_reg     <= '0;
      carry_reg <= 1'b0;
      zero_reg  <= 1'b0;
      err_reg   <= 1'b0;
    end else if (accept && !is_mul) begin
      z_reg     <= alu_z;
      carry_reg <= alu_carry;
      zero_reg  <= alu_zero;
      err_reg   <= alu_err;
    end
`ifdef CALC_MUL_EN
    else if (state_reg == ST_MUL && mul_done) begin
      z_reg     <= mul_product[WIDTH-1:0];
      carry_reg <= |mul_product[2*WIDTH-1:WIDTH];
      zero_reg  <= (mul_product[WIDTH-1:0] == '0);
      err_reg   <= 1'b0;
    end
`endif
  end

  assign z     = z_reg;
  assign carry = carry_reg;
  assign zero  = zero_reg;
  assign err   = err_reg;

endmodule

// File: tb/tb_calc_unit.sv
// tb_calc_unit: scoreboard bench for calc_unit at WIDTH=8. The driver pushes
// the expected result of each accepted op; the monitor pops and compares when
// a result appears, checks latency, hold-stability under backpressure and the
// return to IDLE after each result handshake.
`timescale 1ns/1ps
module tb_calc_unit;

  localparam int W = 8;
`ifdef CALC_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [2:0]   op = '0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         in_ready, out_valid, carry, zero, err;
  logic [W-1:0] z;

  calc_unit #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .z         (z),
    .carry     (carry),
    .zero      (zero),
    .err       (err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int stall = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] z;
    logic         c;
    logic         zr;
    logic         e;
    int           op;
    int           acc;
    int           lat;
  } exp_t;

  exp_t sbq[$];

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference behaviour from plain integer arithmetic modulo 2**W.
  function automatic exp_t model(input int o, input int x, input int y);
    exp_t e;
    int   m = 1 << W;
    int   r = 0;
    e.c = 1'b0; e.e = 1'b0; e.lat = 0; e.acc = 0; e.op = o;
    case (o)
      0: begin r = x + y; e.c = (r >= m); end
      1: begin r = x - y; e.c = (x < y); if (r < 0) r = r + m; end
      2: r = x | y;
      3: r = (m - x) % m;
      4: r = x & y;
      5: r = x ^ y;
      6: begin
        if (MUL_EN) begin r = x * y; e.c = (r >= m); e.lat = W + 1; end
        else e.e = 1'b1;
      end
      default: e.e = 1'b1;
    endcase
    if (e.e) begin r = 0; e.c = 1'b0; end
    e.z  = W'(r % m);
    e.zr = !e.e && ((r % m) == 0);
    return e;
  endfunction

  // Present an op and hold it until accepted; returns on the negedge after accept.
  task automatic issue(input int o, input int x, input int y);
    exp_t e;
    int   k = 0;
    op = 3'(o); a = W'(x); b = W'(y); in_valid = 1'b1;
    while (!in_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) begin
      total++; bad++;
      $display("FAIL accept_timeout: in_ready=%0d required 1", in_ready);
      in_valid = 1'b0;
      return;
    end
    e = model(o, x, y);
    e.acc = cyc + 1;
    sbq.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
    op = 3'($urandom); a = W'($urandom); b = W'($urandom);
  endtask

  task automatic drain();
    int k = 0;
    while ((sbq.size() != 0 || out_valid) && k < 400) begin
      @(negedge clk);
      k++;
    end
    if (k >= 400) begin
      total++; bad++;
      $display("FAIL drain_timeout: pending=%0d required 0", sbq.size());
    end
    @(negedge clk);
  endtask

  // Called at a negedge: hold reset for n edges and check reset values.
  task automatic pulse_reset(input int n);
    rst = 1'b1; in_valid = 1'b0;
    #1 chk("in_ready_during_rst", in_ready, 0);
    repeat (n) @(negedge clk);
    sbq.delete();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_z", z, 0);
    chk("rst_carry", carry, 0);
    chk("rst_zero", zero, 0);
    chk("rst_err", err, 0);
    rst = 1'b0;
    #1 chk("in_ready_after_rst", in_ready, 1);
  endtask

  // Monitor: compares results, drives out_ready, checks holding and return to IDLE.
  initial begin : monitor
    bit           prev_v  = 1'b0;
    bit           hs_prev = 1'b0;
    bit           hs_now;
    int           wait_cnt = 0;
    exp_t         cur;
    logic [W+2:0] held = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_v = 1'b0; hs_prev = 1'b0; wait_cnt = 0; out_ready = 1'b0;
        continue;
      end
      hs_now = 1'b0;
      if (hs_prev) begin
        chk("idle_after_handshake_valid", out_valid, 0);
        chk("idle_after_handshake_ready", in_ready, 1);
      end
      if (out_valid) begin
        wait_cnt = 0;
        chk("in_ready_while_valid", in_ready, 0);
        if (!prev_v) begin
          if (sbq.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_result: z=%0d with no op outstanding", z);
          end else begin
            cur = sbq.pop_front();
            chk($sformatf("op%0d_latency", cur.op), cyc - cur.acc, cur.lat);
            chk($sformatf("op%0d_z", cur.op), z, cur.z);
            chk($sformatf("op%0d_carry", cur.op), carry, cur.c);
            chk($sformatf("op%0d_zero", cur.op), zero, cur.zr);
            chk($sformatf("op%0d_err", cur.op), err, cur.e);
          end
          held = {z, carry, zero, err};
        end else begin
          chk("held_outputs", int'({z, carry, zero, err}), int'(held));
        end
        if (stall > 0) begin
          out_ready = 1'b0;
          stall--;
        end else begin
          out_ready = ($urandom_range(0, 3) != 0);
        end
        hs_now = out_ready;
      end else begin
        out_ready = $urandom_range(0, 1) == 1;
        if (sbq.size() != 0) begin
          wait_cnt++;
          if (wait_cnt > 40) begin
            total++; bad++;
            $display("FAIL result_timeout: out_valid=%0d required 1", out_valid);
            void'(sbq.pop_front());
            wait_cnt = 0;
          end
        end else begin
          wait_cnt = 0;
        end
      end
      prev_v  = out_valid;
      hs_prev = hs_now;
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    repeat (3) @(negedge clk);
    chk("reset_in_ready", in_ready, 0);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_z", z, 0);
    chk("reset_flags", int'({carry, zero, err}), 0);
    rst = 1'b0;
    #1 chk("first_cycle_in_ready", in_ready, 1);
    @(negedge clk);

    // Directed operations.
    issue(0, 200, 100);
    issue(1, 3, 5);
    issue(1, 5, 5);
    issue(3, 1, 0);
    issue(3, 0, 0);
    issue(7, 9, 9);
    issue(6, 15, 17);
    issue(6, 16, 16);
    issue(2, 'hA0, 'h05);
    issue(4, 'h0F, 'hF0);
    issue(0, 255, 1);
    drain();

    // Backpressure: result must hold for 5 cycles, in_valid pulses ignored.
    stall = 5;
    issue(5, 'hF0, 'h3C);
    repeat (3) begin
      in_valid = 1'b1; op = 3'($urandom); a = W'($urandom); b = W'($urandom);
      @(negedge clk);
    end
    in_valid = 1'b0;
    drain();

    // Reset in the fourth cycle of a multiply aborts it.
    issue(6, 200, 201);
    repeat (3) @(negedge clk);
    pulse_reset(1);
    @(negedge clk);
    issue(0, 1, 1);
    drain();

    // Randomised back-to-back traffic.
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 7) == 0) stall = $urandom_range(1, 4);
      issue($urandom_range(0, 7), $urandom_range(0, 255), $urandom_range(0, 255));
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
